// File: rtl/icache_pkg.sv
// Shared types and helpers for the L1 instruction cache: FSM state encoding,
// address-field width helpers and the filler word returned on a non-hit.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    UPDATE = 2'd2
  } icache_state_e;

  localparam logic [31:0] ICACHE_MISS_DATA = 32'hDEADBEEF;

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int offset_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Tag is whatever is left above index, word offset and the 2-bit byte offset.
  function automatic int tag_width(input int addr_width, input int num_sets,
                                   input int words_per_line);
    return addr_width - $clog2(num_sets) - $clog2(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/icache_lru.sv
// True-LRU helper for one set. Ages form a permutation of 0..NUM_WAYS-1,
// 0 = most recently used. Purely combinational; the parent owns the flops.
module icache_lru
  import icache_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] ages,
  input  logic [NUM_WAYS-1:0]            valid,
  input  logic [WAY_W-1:0]               way,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] ages_next,
  output logic [WAY_W-1:0]               victim
);

  logic [WAY_W-1:0] oldest;

  // Promote the accessed way to age 0 and age every younger way by one.
  always_comb begin
    ages_next = ages;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == way) begin
        ages_next[w] = '0;
      end else if (ages[w] < ages[way]) begin
        ages_next[w] = ages[w] + WAY_W'(1);
      end
    end
  end

  // Victim: lowest-index invalid way, else the oldest way. Kept separate from
  // the promotion block because the parent feeds victim back in as `way`.
  always_comb begin
    victim = '0;
    oldest = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages[w] >= oldest) begin
        oldest = ages[w];
        victim = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/l1_nway_instr_cache.sv
// N-way set-associative L1 instruction cache with multi-word lines, true-LRU
// replacement and a blocking line refill over a valid/ack memory port.
// Optional build macro ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module l1_nway_instr_cache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SETS       = 64,
  parameter int NUM_WAYS       = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  cache_hit_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  localparam int IDX_W  = index_width(NUM_SETS);
  localparam int OFF_W  = offset_width(WORDS_PER_LINE);
  localparam int TAG_W  = tag_width(ADDR_WIDTH, NUM_SETS, WORDS_PER_LINE);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int LINE_W = ADDR_WIDTH - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  icache_state_e state;

  // Request address split into line (tag+index) and word offset.
  logic [LINE_W-1:0] addr_line;
  logic [IDX_W-1:0]  addr_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [OFF_W-1:0]  addr_off;
  logic              unused_byte_bits;

  // Refill context latched at miss time.
  logic [LINE_W-1:0] refill_line;
  logic [IDX_W-1:0]  refill_idx;
  logic [TAG_W-1:0]  refill_tag;
  logic [OFF_W-1:0]  word_cnt;
  logic [OFF_W-1:0]  word_cnt_next;
  logic              flush_pending;

  // Valid bits and ages are reset; tags and data are plain storage.
  logic [NUM_WAYS-1:0]            valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0][WAY_W-1:0] age_q   [NUM_SETS];
  logic [TAG_W-1:0]               tag_mem [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0]          data_mem[NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0]          line_buf[WORDS_PER_LINE];

  logic                           lookup_hit;
  logic [WAY_W-1:0]               hit_way;
  logic                           hit;
  logic                           miss;
  logic                           miss_start;
  logic                           fill_en;
  logic                           clear_all;
  logic [IDX_W-1:0]               lru_set;
  logic [WAY_W-1:0]               lru_way;
  logic [NUM_WAYS-1:0][WAY_W-1:0] ages_next;
  logic [WAY_W-1:0]               victim;

  assign addr_line        = addr_i[ADDR_WIDTH-1:OFF_W+2];
  assign addr_idx         = addr_line[IDX_W-1:0];
  assign addr_tag         = addr_line[LINE_W-1:IDX_W];
  assign addr_off         = addr_i[OFF_W+1:2];
  assign unused_byte_bits = ^addr_i[1:0];

  assign refill_idx    = refill_line[IDX_W-1:0];
  assign refill_tag    = refill_line[LINE_W-1:IDX_W];
  assign word_cnt_next = word_cnt + OFF_W'(1);

  // Tag compare across all ways of the addressed set.
  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[addr_idx][w] && (tag_mem[addr_idx][w] == addr_tag)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  assign hit        = (state == IDLE) && req_valid_i && lookup_hit;
  assign miss       = (state == IDLE) && req_valid_i && !lookup_hit;
  // A flush in the miss cycle wins: the refill is not started.
  assign miss_start = miss && !flush_i;

  // A flush arriving in UPDATE, or one held over from REFILL, kills the fill.
  assign fill_en   = (state == UPDATE) && !flush_i && !flush_pending;
  assign clear_all = (flush_i && (state != REFILL)) || ((state == UPDATE) && flush_pending);

  assign cache_hit_o = hit;
  assign stall_o     = (state != IDLE) || miss;
  assign instr_o     = hit ? data_mem[addr_idx][hit_way][addr_off] : ICACHE_MISS_DATA;

  // The LRU helper serves the lookup set in IDLE and the refill set in UPDATE.
  assign lru_set = (state == UPDATE) ? refill_idx : addr_idx;
  assign lru_way = (state == UPDATE) ? victim : hit_way;

  icache_lru #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_lru (
    .ages      (age_q[lru_set]),
    .valid     (valid_q[lru_set]),
    .way       (lru_way),
    .ages_next (ages_next),
    .victim    (victim)
  );

  // Control FSM and registered memory request; reset aborts any refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      refill_line   <= '0;
      word_cnt      <= '0;
      flush_pending <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            state       <= REFILL;
            refill_line <= addr_line;
            word_cnt    <= '0;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= {addr_line, {OFF_W{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (flush_i) flush_pending <= 1'b1;
          if (mem_ack_i) begin
            word_cnt <= word_cnt_next;
            if (word_cnt == LAST_WORD) begin
              mem_req_o <= 1'b0;
              state     <= UPDATE;
            end else begin
              mem_addr_o <= {refill_line, word_cnt_next, 2'b00};
            end
          end
        end
        UPDATE: begin
          flush_pending <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits and LRU ages: touch on hit, install on fill, wipe on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      if (hit) age_q[addr_idx] <= ages_next;
      if (fill_en) begin
        valid_q[refill_idx][victim] <= 1'b1;
        age_q[refill_idx]           <= ages_next;
      end
      if (clear_all) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_q[s] <= '0;
        end
      end
    end
  end

  // Collect refill words; stale contents after an aborted refill are never used.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && mem_ack_i) begin
      line_buf[word_cnt] <= mem_data_i;
    end
  end

  // Install the completed line into the victim way.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[refill_idx][victim] <= refill_tag;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        data_mem[refill_idx][victim][w] <= line_buf[w];
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Saturating hit/miss counters; a flushed miss is not a miss start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit && (hit_cnt_o != 32'hFFFF_FFFF)) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss_start && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_nway_instr_cache.sv
// Scoreboard bench for l1_nway_instr_cache: a timestamp-LRU reference model
// predicts hit/miss per fetch, a memory responder serves refills with optional
// random ack delays, and a monitor pops expectations whenever the cache hits.
module tb_l1_nway_instr_cache;

  localparam int SETS = 64;
  localparam int WAYS = 4;
  localparam int WPL  = 4;
  localparam int LINE_BYTES   = 4 * WPL;
  localparam int MISS_PENALTY = WPL + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] instr_o;
  logic        cache_hit_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  bit zero_wait = 1'b1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
    bit          chk_lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_q[$];

  bit          m_valid[SETS][WAYS];
  int unsigned m_tag  [SETS][WAYS];
  int          m_stamp[SETS][WAYS];
  int          tick = 0;

  l1_nway_instr_cache dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .addr_i      (addr_i),
    .flush_i     (flush_i),
    .instr_o     (instr_o),
    .cache_hit_o (cache_hit_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition never reached", name);
  endtask

  // Instruction memory contents; line 0x100 carries the A0..A3 pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:4] == 28'h10) begin
      w = 32'hA0 + {28'd0, a[3:2]};
    end else begin
      w = (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    end
    return w;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  // Returns 1 on a predicted hit; on a miss installs the line, evicting the
  // least recently used entry when the set is full.
  function automatic bit model_access(input logic [31:0] a);
    int unsigned line = a / LINE_BYTES;
    int          set  = int'(line % SETS);
    int unsigned tag  = line / SETS;
    int          v    = -1;
    tick++;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[set][w] && m_tag[set][w] == tag) begin
        m_stamp[set][w] = tick;
        return 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[set][w] && v < 0) v = w;
    if (v < 0) begin
      v = 0;
      for (int w = 1; w < WAYS; w++)
        if (m_stamp[set][w] < m_stamp[set][v]) v = w;
    end
    m_valid[set][v] = 1'b1;
    m_tag[set][v]   = tag;
    m_stamp[set][v] = tick;
    return 1'b0;
  endfunction

  task automatic push_refill(input logic [31:0] a);
    logic [31:0] base = (a / LINE_BYTES) * LINE_BYTES;
    for (int k = 0; k < WPL; k++) mem_q.push_back(base + 32'(4 * k));
  endtask

  task automatic push_exp(input logic [31:0] a, input bit miss, input bit chk_lat);
    exp_t e;
    e.addr    = a;
    e.data    = mem_word(a);
    e.miss    = miss;
    e.chk_lat = chk_lat;
    sb_q.push_back(e);
  endtask

  task automatic wait_hit(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cache_hit_o && n < 200);
    if (!cache_hit_o) fail_now(name);
  endtask

  task automatic wait_bus(input logic [31:0] a, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req_o && mem_addr_o == a) && n < 100);
    if (!(mem_req_o && mem_addr_o == a)) fail_now(name);
  endtask

  // Entered and left at posedge+1; request held until the cache hits.
  task automatic fetch(input logic [31:0] a);
    bit h = model_access(a);
    push_exp(a, !h, zero_wait);
    if (!h) push_refill(a);
    req_valid_i = 1'b1;
    addr_i      = a;
    wait_hit("fetch_timeout");
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks after 0..3 cycles and checks the held address.
  initial begin
    int          dly = -1;
    logic [31:0] held = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (rst_n && mem_req_o) begin
        if (dly < 0) begin
          dly  = zero_wait ? 0 : int'($urandom_range(0, 3));
          held = mem_addr_o;
        end else begin
          check("mem_addr_stable", mem_addr_o, held);
        end
        if (dly == 0) begin
          if (mem_q.size() == 0) fail_now("unexpected_mem_req");
          else check("mem_addr", mem_addr_o, mem_q.pop_front());
          mem_ack_i  = 1'b1;
          mem_data_i = mem_word(mem_addr_o);
          dly        = -1;
        end else begin
          dly--;
        end
      end else begin
        dly = -1;
      end
    end
  end

  // Monitor: pops one expectation per hit and checks data, miss and penalty.
  initial begin
    int   cyc = 0;
    bit   saw = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || !req_valid_i) begin
        cyc = 0;
        saw = 1'b0;
      end else begin
        cyc++;
        if (cache_hit_o) begin
          check("stall_on_hit", {31'd0, stall_o}, 32'd0);
          if (sb_q.size() == 0) begin
            fail_now("unexpected_hit");
          end else begin
            e = sb_q.pop_front();
            check("instr", instr_o, e.data);
            check("miss_flag", {31'd0, saw}, {31'd0, e.miss});
            if (e.chk_lat && e.miss) check("miss_penalty", 32'(cyc - 1), 32'(MISS_PENALTY));
          end
          cyc = 0;
          saw = 1'b0;
        end else begin
          if (stall_o) saw = 1'b1;
          check("instr_nohit", instr_o, 32'hDEADBEEF);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          t;
    int          idx;
    int          wd;

    model_clear();
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_hit", {31'd0, cache_hit_o}, 32'd0);
    check("rst_instr", instr_o, 32'hDEADBEEF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First line: miss on 0x104, refill 0x100..0x10C, then hits.
    zero_wait = 1'b1;
    fetch(32'h0000_0104);
    fetch(32'h0000_0100);
    fetch(32'h0000_0108);
    fetch(32'h0000_010C);

    // Five lines in set 0 with a re-touch of the first before the fifth fill.
    for (int i = 1; i <= 4; i++) fetch(32'(i * 1024));
    fetch(32'd1024);
    fetch(32'(5 * 1024));
    fetch(32'd1024);
    fetch(32'(2 * 1024));

    // Flush during the second refill word: fill discarded, same address re-misses.
    b = 32'd1024;
    a = 32'h0001_0048;
    void'(model_access(a));
    push_exp(a, 1'b1, 1'b0);
    push_refill(a);
    push_refill(a);
    req_valid_i = 1'b1;
    addr_i      = a;
    wait_bus(32'h0001_0044, "flush_wait_word1");
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    model_clear();
    void'(model_access(a));
    t = 0;
    while (mem_req_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("flush_update_hit", {31'd0, cache_hit_o}, 32'd0);
    @(negedge clk);
    check("flush_remiss_stall", {31'd0, stall_o}, 32'd1);
    check("flush_remiss_hit", {31'd0, cache_hit_o}, 32'd0);
    wait_hit("flush_refill_timeout");
    @(posedge clk);
    #1;
    fetch(b);

    // Flush and miss in the same IDLE cycle: no refill starts that cycle.
    a = 32'h0003_0200;
    model_clear();
    void'(model_access(a));
    push_exp(a, 1'b1, 1'b0);
    push_refill(a);
    req_valid_i = 1'b1;
    addr_i      = a;
    flush_i     = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_beats_miss", {31'd0, mem_req_o}, 32'd0);
    wait_hit("flush_idle_timeout");
    @(posedge clk);
    #1;
    fetch(b);

    // Reset while a refill is in flight.
    a = 32'h0002_0100;
    void'(model_access(a));
    push_refill(a);
    req_valid_i = 1'b1;
    addr_i      = a;
    wait_bus(32'h0002_0104, "rst_wait_word1");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_abort_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_abort_addr", mem_addr_o, 32'd0);
    mem_q.delete();
    model_clear();
    req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fetch(a);

    // Random fetches over a few crowded sets with random ack delays.
    zero_wait = 1'b0;
    for (int i = 0; i < 80; i++) begin
      t   = int'($urandom_range(0, 5));
      idx = int'($urandom_range(0, 2));
      wd  = int'($urandom_range(0, WPL - 1));
      fetch(32'(((t * SETS + idx) * WPL + wd) * 4));
    end
    zero_wait = 1'b1;
    for (int i = 0; i < 20; i++) begin
      t   = int'($urandom_range(0, 5));
      idx = int'($urandom_range(0, 2));
      wd  = int'($urandom_range(0, WPL - 1));
      fetch(32'(((t * SETS + idx) * WPL + wd) * 4));
    end
    req_valid_i = 1'b0;

`ifdef ICACHE_PERF_CNT_EN
    rst_n = 1'b0;
    model_clear();
    mem_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fetch(32'h0000_3000);
    fetch(32'h0000_3040);
    fetch(32'h0000_3000);
    req_valid_i = 1'b0;
    @(negedge clk);
    check("hit_cnt", hit_cnt_o, 32'd3);
    check("miss_cnt", miss_cnt_o, 32'd2);
`endif

    repeat (3) @(negedge clk);
    check("sb_left", 32'(sb_q.size()), 32'd0);
    check("mem_q_left", 32'(mem_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
